// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings, shadow-stage records and small helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       md_start;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] tnew;
  } m_stage_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $0 is hard-wired, so it never matches a producer.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] wa);
    return (src != 5'd0) && (src == wa);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div busy window: loads the unit latency when a mult/div enters E, then counts down to zero.
module md_busy_counter #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= div ? DIV_LD : MULT_LD;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline: shadow E/M/W write info, Tuse/Tnew stall
// detection, forwarding selects and the mult/div busy interlock.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_WA,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt,
  output logic       fwd_M_rt,
  output logic       md_busy
);

  e_stage_t   e_reg;
  m_stage_t   m_reg;
  logic [4:0] w_wa_reg;
  e_stage_t   e_next;
  m_stage_t   m_next;

  logic [1:0]       hz_op;
  logic [1:0][1:0]  fwd_d_op;
  logic [1:0][1:0]  fwd_e_op;
  logic             hz_md;

  logic [1:0][4:0]  d_src;
  logic [1:0][1:0]  d_tuse;
  logic [1:0][4:0]  e_src;

  assign d_src  = {D_rt, D_rs};
  assign d_tuse = {D_Tuse_rt, D_Tuse_rs};
  assign e_src  = {e_reg.rt, e_reg.rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic       hz_l;
      logic [1:0] fwd_d_l;
      logic [1:0] fwd_e_l;

      always_comb begin
        hz_l = (d_tuse[gi] != TUSE_NONE) &&
               ((reg_hit(d_src[gi], e_reg.wa) && (d_tuse[gi] < e_reg.tnew)) ||
                (reg_hit(d_src[gi], m_reg.wa) && (d_tuse[gi] < m_reg.tnew)));

        // Only the nearest producer counts; if it is not ready yet the stall covers it.
        fwd_d_l = FWD_GRF;
        if (reg_hit(d_src[gi], e_reg.wa)) begin
          fwd_d_l = (e_reg.tnew == 2'd0) ? FWD_E : FWD_GRF;
        end else if (reg_hit(d_src[gi], m_reg.wa)) begin
          fwd_d_l = (m_reg.tnew == 2'd0) ? FWD_M : FWD_GRF;
        end else if (reg_hit(d_src[gi], w_wa_reg)) begin
          fwd_d_l = FWD_W;
        end

        fwd_e_l = FWD_GRF;
        if (reg_hit(e_src[gi], m_reg.wa)) begin
          fwd_e_l = (m_reg.tnew == 2'd0) ? FWD_M : FWD_GRF;
        end else if (reg_hit(e_src[gi], w_wa_reg)) begin
          fwd_e_l = FWD_W;
        end
      end

      assign hz_op[gi]    = hz_l;
      assign fwd_d_op[gi] = fwd_d_l;
      assign fwd_e_op[gi] = fwd_e_l;
    end
  endgenerate

  assign hz_md    = D_md_use && (md_busy || e_reg.md_start);
  assign stall    = hz_op[0] | hz_op[1] | hz_md;
  assign fwd_D_rs = fwd_d_op[0];
  assign fwd_D_rt = fwd_d_op[1];
  assign fwd_E_rs = fwd_e_op[0];
  assign fwd_E_rt = fwd_e_op[1];
  assign fwd_M_rt = reg_hit(m_reg.rt, w_wa_reg);

  always_comb begin
    e_next = '0;
    if (!stall) begin
      e_next = '{rs: D_rs, rt: D_rt, wa: D_WA, tnew: D_Tnew, md_start: D_md_start};
    end
    m_next = '{rt: e_reg.rt, wa: e_reg.wa, tnew: tnew_dec(e_reg.tnew)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_reg    <= '0;
      m_reg    <= '0;
      w_wa_reg <= '0;
    end else begin
      e_reg    <= e_next;
      m_reg    <= m_next;
      w_wa_reg <= m_reg.wa;
    end
  end

  md_busy_counter #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC),
    .CNT_W   (CNT_W)
  ) u_md_cnt (
    .clk  (clk),
    .reset(reset),
    .load (D_md_start && !stall),
    .div  (D_md_div),
    .busy (md_busy)
  );

endmodule
